// File: rtl/seq_int_ctrl.sv
// Interrupt request/dispatch controller: IF/IE/IME, EI delay, priority vectoring, HALT sleep/wake.
// Optional build macro SEQ_INT_HALT_BUG_EN adds the HALT_BUG output.
module seq_int_ctrl #(
   parameter int         NUM_IRQ         = 5,
   parameter logic [7:0] VEC_BASE        = 8'h40,
   parameter int         VEC_STRIDE      = 8,
   parameter int         DISPATCH_CYCLES = 5
) (
   input  logic               CLK,
   input  logic               SYNC_RESET,
   input  logic [NUM_IRQ-1:0] IRQ_IN,
   input  logic [7:0]         DATA_IN,
   input  logic               IF_WE,
   input  logic               IE_WE,
   output logic [7:0]         IF_OUT,
   output logic [7:0]         IE_OUT,
   input  logic               EI_EXEC,
   input  logic               DI_EXEC,
   input  logic               RETI_EXEC,
   input  logic               HALT_EXEC,
   input  logic               INSN_BOUNDARY,
   output logic               INT_REQ,
   input  logic               INT_ACK,
   output logic [7:0]         VECTOR,
   output logic               IME,
   output logic               BUSY,
   output logic               HALTED,
`ifdef SEQ_INT_HALT_BUG_EN
   output logic               HALT_BUG,
`endif
   output logic               WAKE
);

   localparam int               CNT_W    = $clog2(DISPATCH_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DISPATCH_CYCLES - 1);
   localparam logic [7:0]       IF_PAD   = ~((8'd1 << NUM_IRQ) - 8'd1);

   typedef enum logic [1:0] {ST_RUN, ST_HALT, ST_DISPATCH} state_e;

   state_e             state_q;
   logic [NUM_IRQ-1:0] if_q, if_d;
   logic [7:0]         ie_q, ie_d;
   logic               ime_q, ime_d;
   logic               ei_pend_q, ei_pend_d;
   logic [7:0]         vector_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               wake_q;
   logic               halt_bug_q;

   logic [NUM_IRQ-1:0] pend, if_wr, pend_ack, ack_low;
   logic [7:0]         ie_wr, ack_vec;
   logic               ack_run;

   assign pend    = if_q & ie_q[NUM_IRQ-1:0];
   assign ack_run = INT_ACK && (state_q == ST_RUN);

   // An acknowledge sees same-cycle IF/IE writes, so a write can withdraw the request.
   assign if_wr    = IF_WE ? DATA_IN[NUM_IRQ-1:0] : if_q;
   assign ie_wr    = IE_WE ? DATA_IN : ie_q;
   assign pend_ack = if_wr & ie_wr[NUM_IRQ-1:0];

   // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
   always_comb begin
      ack_low = '0;
      ack_vec = 8'h00;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (pend_ack[i]) begin
            ack_low    = '0;
            ack_low[i] = 1'b1;
            ack_vec    = 8'(int'(VEC_BASE) + VEC_STRIDE * i);
         end
      end
   end

   always_comb begin
      ie_d = ie_wr;
      if_d = ack_run ? (if_wr & ~ack_low) : if_wr;
      if_d = if_d | IRQ_IN;

      ime_d     = ime_q;
      ei_pend_d = ei_pend_q;
      if (ei_pend_q && INSN_BOUNDARY) begin
         ime_d     = 1'b1;
         ei_pend_d = 1'b0;
      end
      if (EI_EXEC)   ei_pend_d = 1'b1;
      if (RETI_EXEC) ime_d     = 1'b1;
      if (DI_EXEC || ack_run) begin
         ime_d     = 1'b0;
         ei_pend_d = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge CLK) begin
      if (SYNC_RESET) begin
         state_q    <= ST_RUN;
         if_q       <= '0;
         ie_q       <= 8'h00;
         ime_q      <= 1'b0;
         ei_pend_q  <= 1'b0;
         vector_q   <= 8'h00;
         cnt_q      <= '0;
         wake_q     <= 1'b0;
         halt_bug_q <= 1'b0;
      end else begin
         if_q       <= if_d;
         ie_q       <= ie_d;
         ime_q      <= ime_d;
         ei_pend_q  <= ei_pend_d;
         wake_q     <= 1'b0;
         halt_bug_q <= 1'b0;
         case (state_q)
            ST_RUN: begin
               if (INT_ACK) begin
                  state_q  <= ST_DISPATCH;
                  vector_q <= ack_vec;
                  cnt_q    <= CNT_LOAD;
               end else if (HALT_EXEC) begin
                  if (pend == '0) begin
                     state_q <= ST_HALT;
                  end
`ifdef SEQ_INT_HALT_BUG_EN
                  else if (!ime_q) begin
                     halt_bug_q <= 1'b1;
                  end
`endif
               end
            end
            ST_HALT: begin
               if (pend != '0) begin
                  state_q <= ST_RUN;
                  wake_q  <= 1'b1;
               end
            end
            ST_DISPATCH: begin
               if (cnt_q == '0) state_q <= ST_RUN;
               else             cnt_q   <= cnt_q - 1'b1;
            end
            default: state_q <= ST_RUN;
         endcase
      end
   end

   assign IF_OUT  = IF_PAD | 8'(if_q);
   assign IE_OUT  = ie_q;
   assign IME     = ime_q;
   assign VECTOR  = vector_q;
   assign INT_REQ = (state_q == ST_RUN) && ime_q && (pend != '0);
   assign BUSY    = (state_q == ST_DISPATCH);
   assign HALTED  = (state_q == ST_HALT);
   assign WAKE    = wake_q;
`ifdef SEQ_INT_HALT_BUG_EN
   assign HALT_BUG = halt_bug_q;
`else
   logic unused_halt_bug;
   assign unused_halt_bug = halt_bug_q;
`endif

endmodule

// File: tb/tb_seq_int_ctrl.sv
// Directed self-checking bench for seq_int_ctrl; hand-computed expectations.
module tb_seq_int_ctrl;

   logic       clk = 1'b0;
   logic       sync_reset;
   logic [4:0] irq_in;
   logic [7:0] data_in;
   logic       if_we, ie_we, ei_exec, di_exec, reti_exec, halt_exec, insn_boundary, int_ack;
   logic [7:0] if_out, ie_out, vector;
   logic       int_req, ime, busy, halted, wake;
`ifdef SEQ_INT_HALT_BUG_EN
   logic       halt_bug;
`endif

   int n_chk = 0;
   int n_bad = 0;

   seq_int_ctrl dut (
      .CLK          (clk),
      .SYNC_RESET   (sync_reset),
      .IRQ_IN       (irq_in),
      .DATA_IN      (data_in),
      .IF_WE        (if_we),
      .IE_WE        (ie_we),
      .IF_OUT       (if_out),
      .IE_OUT       (ie_out),
      .EI_EXEC      (ei_exec),
      .DI_EXEC      (di_exec),
      .RETI_EXEC    (reti_exec),
      .HALT_EXEC    (halt_exec),
      .INSN_BOUNDARY(insn_boundary),
      .INT_REQ      (int_req),
      .INT_ACK      (int_ack),
      .VECTOR       (vector),
      .IME          (ime),
      .BUSY         (busy),
      .HALTED       (halted),
`ifdef SEQ_INT_HALT_BUG_EN
      .HALT_BUG     (halt_bug),
`endif
      .WAKE         (wake)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One clock edge, then clear all one-cycle pulse inputs.
   task automatic tick();
      @(posedge clk);
      #1;
      irq_in = '0; if_we = 0; ie_we = 0; ei_exec = 0; di_exec = 0;
      reti_exec = 0; halt_exec = 0; insn_boundary = 0; int_ack = 0; sync_reset = 0;
   endtask

   task automatic wait_dispatch_end();
      int n = 0;
      while (busy && n < 20) begin
         tick();
         n++;
      end
      check("dispatch_end", busy, 0);
   endtask

   initial begin
      int n;
      sync_reset = 1; irq_in = '0; data_in = 0; if_we = 0; ie_we = 0; ei_exec = 0; di_exec = 0;
      reti_exec = 0; halt_exec = 0; insn_boundary = 0; int_ack = 0;
      @(posedge clk); #1;
      sync_reset = 1;
      tick();

      check("rst_if", if_out, 8'hE0);
      check("rst_ie", ie_out, 8'h00);
      check("rst_ime", ime, 0);
      check("rst_req", int_req, 0);
      check("rst_busy", busy, 0);
      check("rst_halted", halted, 0);
      check("rst_wake", wake, 0);
      check("rst_vec", vector, 8'h00);

      // Register readback widths.
      ie_we = 1; if_we = 1; data_in = 8'hA5; tick();
      check("ie_all_bits", ie_out, 8'hA5);
      check("if_pad", if_out, 8'hE5);
      if_we = 1; data_in = 8'h00; tick();
      check("if_clear", if_out, 8'hE0);

      // Single request, RETI enable, acknowledge and 5-cycle dispatch.
      ie_we = 1; data_in = 8'h1F; tick();
      irq_in = 5'b00100; tick();
      check("t1_if", if_out, 8'hE4);
      check("t1_req_masked", int_req, 0);
      reti_exec = 1; tick();
      check("t1_ime", ime, 1);
      check("t1_req", int_req, 1);
      int_ack = 1; tick();
      check("t1_vec", vector, 8'h50);
      check("t1_if_clr", if_out, 8'hE0);
      check("t1_ime_clr", ime, 0);
      check("t1_req_busy", int_req, 0);
      n = 0;
      while (busy && n < 20) begin
         n++;
         tick();
      end
      check("t1_busy_len", n, 5);

      // Two simultaneous sources: bit1 wins, bit4 waits for RETI.
      reti_exec = 1; tick();
      irq_in = 5'b10010; tick();
      check("t2_if", if_out, 8'hF2);
      check("t2_req", int_req, 1);
      int_ack = 1; tick();
      check("t2_vec", vector, 8'h48);
      check("t2_if_left", if_out, 8'hF0);
      wait_dispatch_end();
      check("t2_req_masked", int_req, 0);
      reti_exec = 1; tick();
      check("t2_req_reti", int_req, 1);
      int_ack = 1; tick();
      check("t2_vec4", vector, 8'h60);
      wait_dispatch_end();

      // EI delay until instruction boundary; DI cancels a pending EI.
      ie_we = 1; if_we = 1; data_in = 8'h01; tick();
      ei_exec = 1; tick();
      check("t3_req_ei0", int_req, 0);
      tick();
      check("t3_req_ei1", int_req, 0);
      insn_boundary = 1; tick();
      check("t3_req_bnd", int_req, 1);
      di_exec = 1; tick();
      check("t3_req_di", int_req, 0);
      ei_exec = 1; tick();
      di_exec = 1; tick();
      insn_boundary = 1; tick();
      check("t3_req_cancel", int_req, 0);
      check("t3_ime_cancel", ime, 0);

      // Withdrawn request: IE cleared in the acknowledge cycle.
      reti_exec = 1; tick();
      check("t5_req", int_req, 1);
      ie_we = 1; data_in = 8'h00; int_ack = 1; tick();
      check("t5_vec0", vector, 8'h00);
      check("t5_if_kept", if_out, 8'hE1);
      check("t5_busy", busy, 1);
      wait_dispatch_end();
      if_we = 1; data_in = 8'h00; irq_in = 5'b00001; tick();
      check("t5_set_wins", if_out, 8'hE1);
      if_we = 1; data_in = 8'h00; tick();
      check("t5_if_wr0", if_out, 8'hE0);

      // HALT sleep and wake with IME=0.
      ie_we = 1; data_in = 8'h04; tick();
      halt_exec = 1; tick();
      check("t4_halted", halted, 1);
      irq_in = 5'b00100; tick();
      check("t4_still_halt", halted, 1);
      check("t4_wake_early", wake, 0);
      tick();
      check("t4_wake", wake, 1);
      check("t4_run", halted, 0);
      check("t4_req", int_req, 0);
      tick();
      check("t4_wake_pulse", wake, 0);
      halt_exec = 1; tick();
      check("t4_no_sleep", halted, 0);
`ifdef SEQ_INT_HALT_BUG_EN
      check("t4_halt_bug", halt_bug, 1);
      tick();
      check("t4_halt_bug_pulse", halt_bug, 0);
`endif

      // Acknowledge without INT_REQ, then reset in dispatch cycle 2.
      int_ack = 1; tick();
      check("t6_vec", vector, 8'h50);
      check("t6_busy1", busy, 1);
      tick();
      check("t6_busy2", busy, 1);
      sync_reset = 1; reti_exec = 1; irq_in = 5'b00001; tick();
      check("t6_busy", busy, 0);
      check("t6_ime", ime, 0);
      check("t6_if", if_out, 8'hE0);
      check("t6_ie", ie_out, 8'h00);
      check("t6_vec0", vector, 8'h00);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/seq_int_ctrl.md
Name: seq_int_ctrl

Overview:
- Interrupt request/dispatch controller that schedules the CPU sequencer's interrupt entry.
- Holds the IF/IE registers and the IME flag, including the EI one-instruction delay.
- Priority-encodes pending requests, handshakes dispatch with the sequencer, and supplies the vector address.
- Also manages HALT sleep/wake; sits between the peripheral IRQ lines and the sequencer's interrupt state path.

Parameters:
- NUM_IRQ, 5, number of request sources; bit 0 has highest priority.
- VEC_BASE, 8'h40, vector of source 0.
- VEC_STRIDE, 8, vector spacing between sources.
- DISPATCH_CYCLES, 5, CLK cycles the controller stays in DISPATCH after acknowledge.

Ports:
- CLK  in  1  single clock, all state on rising edge.
- SYNC_RESET  in  1  synchronous reset, active-high.
- IRQ_IN  in  NUM_IRQ  one-cycle request pulses from peripherals.
- DATA_IN  in  8  register write data.
- IF_WE  in  1  write IF from DATA_IN.
- IE_WE  in  1  write IE from DATA_IN.
- IF_OUT  out  8  IF readback; bits above NUM_IRQ read 1.
- IE_OUT  out  8  IE readback; all 8 bits stored.
- EI_EXEC  in  1  EI decoded, one-cycle pulse.
- DI_EXEC  in  1  DI decoded, one-cycle pulse.
- RETI_EXEC  in  1  RETI executed, one-cycle pulse.
- HALT_EXEC  in  1  HALT decoded, one-cycle pulse.
- INSN_BOUNDARY  in  1  opcode-fetch (M1) boundary pulse.
- INT_REQ  out  1  dispatch request to sequencer.
- INT_ACK  in  1  sequencer entered interrupt entry, one-cycle pulse.
- VECTOR  out  8  latched dispatch vector.
- IME  out  1  master enable.
- BUSY  out  1  high in DISPATCH.
- HALTED  out  1  high in HALT.
- WAKE  out  1  one-cycle wake pulse.

Behaviour:
Reset:
- IF=0, IE=0, IME=0, ei_pend=0, state=RUN, VECTOR=8'h00, counter=0.
- INT_REQ, BUSY, HALTED and WAKE are all 0.
- Reset mid-DISPATCH or mid-HALT aborts to RUN; reset has priority over all inputs.

Registers:
- pend = IF & IE[NUM_IRQ-1:0].
- IF next value, applied in this order: IF_WE load; then clear of the acknowledged bit; then OR IRQ_IN. A set therefore wins over a clear or a write in the same cycle.
- Latency: IRQ_IN at cycle n gives the IF bit at n+1, and INT_REQ no earlier than n+1.

IME:
- DI_EXEC: IME=0 and ei_pend=0 next cycle.
- EI_EXEC: ei_pend=1. IME is set at the first INSN_BOUNDARY after EI, so the instruction following EI executes unmasked by interrupts.
- EI and DI in the same cycle: DI wins.
- RETI_EXEC: IME=1 next cycle with no delay.
- INT_ACK: IME=0 and ei_pend=0.

State machine:
- RUN:
  - INT_REQ = IME & |pend (combinational from registers).
  - INT_ACK → DISPATCH. In the same edge: latch VECTOR = VEC_BASE + VEC_STRIDE*k for the lowest set k of pend, clear IF[k], load counter=DISPATCH_CYCLES-1.
  - If pend==0 at INT_ACK (request withdrawn by IE/IF write): VECTOR=8'h00 and no IF bit is cleared.
  - INT_ACK while INT_REQ=0 is still honoured as above.
  - HALT_EXEC with pend==0 → HALT.
  - HALT_EXEC with pend!=0: stay in RUN (no sleep).
- HALT:
  - HALTED=1, INT_REQ=0.
  - When pend!=0, regardless of IME: WAKE=1 for one cycle and → RUN. INT_REQ may assert the following cycle.
- DISPATCH:
  - BUSY=1, INT_REQ=0.
  - Counter decrements each cycle; at 0 → RUN.
  - INT_ACK and HALT_EXEC are ignored in this state.
  - IF sets and register writes continue normally.

Priority within a cycle: SYNC_RESET > INT_ACK > HALT_EXEC.

Optional Feature:
SEQ_INT_HALT_BUG_EN
- Defined: adds output HALT_BUG (1 bit, reset 0). HALT_EXEC in RUN with IME=0 and pend!=0 pulses HALT_BUG for one cycle, so the sequencer can suppress the next PC increment. No sleep occurs.
- Undefined: the port is absent and this case is a plain no-sleep.

Test Plan:
- Reset, write IE=8'h1F, IRQ_IN=5'b00100, then RETI_EXEC → IF_OUT=8'hE4, IME=1, INT_REQ=1. INT_ACK → VECTOR=8'h50, IF_OUT=8'hE0, IME=0, BUSY=1 for exactly 5 cycles.
- IE=8'h1F, IME=1, IRQ_IN=5'b10010 together → INT_ACK gives VECTOR=8'h48. IF bit4 stays set; INT_REQ re-asserts only after RETI_EXEC.
- EI_EXEC with IF=IE=8'h01 → INT_REQ=0 until the first INSN_BOUNDARY edge, then 1. Repeat with DI_EXEC before the boundary → INT_REQ stays 0.
- HALT_EXEC with IME=0, IE=8'h04, IF=0 → HALTED=1. IRQ_IN=5'b00100 → WAKE pulses 1 cycle, HALTED=0, INT_REQ=0. With the macro: HALT_EXEC while IF=IE=8'h04 → HALT_BUG=1 for one cycle, HALTED stays 0.
- INT_REQ=1 (IF=IE=8'h01), IE_WE=1 with DATA_IN=8'h00 in the same cycle as INT_ACK → VECTOR=8'h00, IF unchanged. IF_WE with 8'h00 plus IRQ_IN bit0 in the same cycle → IF bit0=1.
- SYNC_RESET asserted in cycle 2 of DISPATCH → next cycle BUSY=0, IME=0, IF_OUT=8'hE0, IE_OUT=8'h00, VECTOR=8'h00.
